uart_tx_fifo: RTL and testbench

- Downstream consumer of the core's UART byte strobe (`tx_start`/`tx_data`).
- Buffers bytes in a small synchronous FIFO and serialises them onto the board TX pin as 8N1 frames at a fixed baud.
- Lets the core strobe bytes faster than line rate without losing data, up to FIFO depth.
- Reports full, overflow and busy status back to the core.

---
 rtl/uart_tx_fifo.sv | 182 ++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// Byte FIFO in front of an 8N1 UART transmitter.
// Bytes strobed by the core are queued and sent back-to-back at a fixed baud.
module uart_tx_fifo #(
    parameter int CLK_FREQ   = 24000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       tx,
    output logic       full,
    output logic       empty,
    output logic       busy,
    output logic       overflow
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int PTR_W        = $clog2(FIFO_DEPTH);
    localparam int CNT_W        = PTR_W + 1;
    localparam int BAUD_W       = $clog2(CLKS_PER_BIT);

    localparam logic [BAUD_W-1:0] BAUD_LAST  = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  COUNT_FULL = CNT_W'(FIFO_DEPTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic [7:0]        mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              overflow_q, overflow_d;
    logic [1:0]        state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [7:0]        shift_q, shift_d;
    logic              tx_q, tx_d;
    logic              pop_req_s;
    logic              wr_en_s;
    logic              pop_s;
    logic              baud_done_s;

    assign full     = (count_q == COUNT_FULL);
    assign empty    = (count_q == {CNT_W{1'b0}});
    assign busy     = (state_q != S_IDLE) || !empty;
    assign tx       = tx_q;
    assign overflow = overflow_q;

    assign baud_done_s = (baud_q == BAUD_LAST);

    // Frame sequencer: the head byte is popped on the same edge that drives the start bit.
    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        pop_req_s = 1'b0;
        case (state_q)
            S_IDLE: begin
                baud_d    = {BAUD_W{1'b0}};
                bit_idx_d = 3'd0;
                if (!empty) begin
                    pop_req_s = 1'b1;
                    shift_d   = mem_q[rd_ptr_q];
                    state_d   = S_START;
                    tx_d      = 1'b0;
                end else begin
                    tx_d      = 1'b1;
                end
            end
            S_START: begin
                if (baud_done_s) begin
                    baud_d    = {BAUD_W{1'b0}};
                    bit_idx_d = 3'd0;
                    state_d   = S_DATA;
                    tx_d      = shift_q[0];
                end else begin
                    baud_d    = baud_q + BAUD_W'(1);
                    tx_d      = 1'b0;
                end
            end
            S_DATA: begin
                if (baud_done_s) begin
                    baud_d = {BAUD_W{1'b0}};
                    if (bit_idx_q == 3'd7) begin
                        state_d = S_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        shift_d   = {1'b0, shift_q[7:1]};
                        bit_idx_d = bit_idx_q + 3'd1;
                        tx_d      = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                    tx_d   = shift_q[0];
                end
            end
            S_STOP: begin
                if (baud_done_s) begin
                    baud_d = {BAUD_W{1'b0}};
                    if (!empty) begin
                        pop_req_s = 1'b1;
                        shift_d   = mem_q[rd_ptr_q];
                        state_d   = S_START;
                        tx_d      = 1'b0;
                    end else begin
                        state_d   = S_IDLE;
                        tx_d      = 1'b1;
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                    tx_d   = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                baud_d  = {BAUD_W{1'b0}};
                tx_d    = 1'b1;
            end
        endcase
    end

    // FIFO bookkeeping; a write while full is dropped even if a pop frees a slot this cycle.
    always_comb begin
        wr_en_s    = tx_start && !full;
        pop_s      = pop_req_s && !empty;
        overflow_d = overflow_q | (tx_start & full);
        if (wr_en_s) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({wr_en_s, pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Byte storage needs no reset; only pointers and count define validity.
    always_ff @(posedge clock) begin
        if (wr_en_s) begin
            mem_q[wr_ptr_q] <= tx_data;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            wr_ptr_q   <= {PTR_W{1'b0}};
            rd_ptr_q   <= {PTR_W{1'b0}};
            count_q    <= {CNT_W{1'b0}};
            overflow_q <= 1'b0;
            state_q    <= S_IDLE;
            baud_q     <= {BAUD_W{1'b0}};
            bit_idx_q  <= 3'd0;
            shift_q    <= 8'd0;
            tx_q       <= 1'b1;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo at 10 clocks per bit and a 4-entry FIFO.
// A line monitor decodes frames; each test compares them to hand-built expectations.
module tb_uart_tx_fifo;

    logic       clock;
    logic       reset_n;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx;
    logic       full;
    logic       empty;
    logic       busy;
    logic       overflow;

    int n_chk;
    int n_pass;
    int cyc;

    logic [7:0] byte_q[$];
    int         start_q[$];
    logic [7:0] exp_q[$];

    bit         mon_busy;
    int         mon_cnt;
    int         mon_start;
    logic [7:0] mon_byte;

    uart_tx_fifo #(
        .CLK_FREQ   (1000),
        .BAUD       (100),
        .FIFO_DEPTH (4)
    ) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .tx       (tx),
        .full     (full),
        .empty    (empty),
        .busy     (busy),
        .overflow (overflow)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clock);
            cyc++;
        end
    end

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Line monitor: samples mid-bit on the falling edge, abandons a frame on reset.
    initial begin
        mon_busy  = 1'b0;
        mon_cnt   = 0;
        mon_start = 0;
        mon_byte  = 8'd0;
        forever begin
            @(negedge clock);
            if (!reset_n) begin
                mon_busy = 1'b0;
            end else if (!mon_busy) begin
                if (tx == 1'b0) begin
                    mon_busy  = 1'b1;
                    mon_cnt   = 0;
                    mon_start = cyc;
                end
            end else begin
                mon_cnt++;
            end
            if (mon_busy && reset_n && (mon_cnt % 10 == 5)) begin
                if (mon_cnt / 10 == 0) begin
                    chk_eq("start_bit", {31'd0, tx}, 32'd0);
                end else if (mon_cnt / 10 <= 8) begin
                    mon_byte[mon_cnt / 10 - 1] = tx;
                end else begin
                    chk_eq("stop_bit", {31'd0, tx}, 32'd1);
                    byte_q.push_back(mon_byte);
                    start_q.push_back(mon_start);
                    mon_busy = 1'b0;
                end
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset_n  = 1'b0;
        tx_start = 1'b0;
        repeat (2) step();
        reset_n = 1'b1;
        byte_q.delete();
        start_q.delete();
        exp_q.delete();
    endtask

    task automatic write_burst(input logic [7:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            tx_data  = base + i[7:0];
            tx_start = 1'b1;
            step();
        end
        tx_start = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while ((busy || mon_busy) && n < 3000) begin
            step();
            n++;
        end
        chk_eq({tag, "_idle"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic check_frames(input string tag);
        chk_eq({tag, "_nframes"}, byte_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < byte_q.size(); i++) begin
            chk_eq($sformatf("%s_byte%0d", tag, i), {24'd0, byte_q[i]}, {24'd0, exp_q[i]});
            if (i > 0) begin
                chk_eq($sformatf("%s_gap%0d", tag, i), start_q[i] - start_q[i-1], 32'd100);
            end
        end
        byte_q.delete();
        start_q.delete();
        exp_q.delete();
    endtask

    task automatic wait_first_frame(input string tag, output int c1);
        int n;
        n = 0;
        while (start_q.size() == 0 && !mon_busy && n < 200) begin
            step();
            n++;
        end
        chk_eq({tag, "_frame_seen"}, {31'd0, mon_busy}, 32'd1);
        c1 = mon_start;
    endtask

    initial begin
        int         errs;
        int         c1;
        int         lows;
        int         wi;
        int         guard;
        logic [7:0] bv;
        logic       exp_bit;

        n_chk    = 0;
        n_pass   = 0;
        reset_n  = 1'b0;
        tx_start = 1'b0;
        tx_data  = 8'd0;
        repeat (3) step();
        reset_n = 1'b1;

        chk_eq("rst_tx", {31'd0, tx}, 32'd1);
        chk_eq("rst_full", {31'd0, full}, 32'd0);
        chk_eq("rst_empty", {31'd0, empty}, 32'd1);
        chk_eq("rst_busy", {31'd0, busy}, 32'd0);
        chk_eq("rst_overflow", {31'd0, overflow}, 32'd0);

        // Single byte 0xA5, cycle-exact.
        bv       = 8'hA5;
        tx_data  = bv;
        tx_start = 1'b1;
        step();
        tx_start = 1'b0;
        chk_eq("a5_tx_after_write", {31'd0, tx}, 32'd1);
        chk_eq("a5_empty_after_write", {31'd0, empty}, 32'd0);
        chk_eq("a5_busy_after_write", {31'd0, busy}, 32'd1);
        step();
        chk_eq("a5_first_low", {31'd0, tx}, 32'd0);
        chk_eq("a5_empty_after_pop", {31'd0, empty}, 32'd1);
        errs = 0;
        for (int k = 0; k < 100; k++) begin
            if (k > 0) begin
                step();
            end
            if (k / 10 == 0) begin
                exp_bit = 1'b0;
            end else if (k / 10 == 9) begin
                exp_bit = 1'b1;
            end else begin
                exp_bit = bv[k / 10 - 1];
            end
            if (tx !== exp_bit || busy !== 1'b1) begin
                errs++;
            end
        end
        chk_eq("a5_cycle_exact_errs", errs, 32'd0);
        step();
        chk_eq("a5_busy_drop", {31'd0, busy}, 32'd0);
        chk_eq("a5_empty_end", {31'd0, empty}, 32'd1);
        chk_eq("a5_tx_idle", {31'd0, tx}, 32'd1);
        exp_q.push_back(8'hA5);
        check_frames("a5");

        // Burst of three bytes held on consecutive cycles.
        write_burst(8'h01, 3);
        wait_idle("burst");
        chk_eq("burst_overflow", {31'd0, overflow}, 32'd0);
        exp_q.push_back(8'h01);
        exp_q.push_back(8'h02);
        exp_q.push_back(8'h03);
        check_frames("burst");

        // Six consecutive writes into a 4-deep FIFO: the sixth is dropped.
        for (int i = 0; i < 6; i++) begin
            tx_data  = 8'h30 + i[7:0];
            tx_start = 1'b1;
            step();
            chk_eq($sformatf("ovf_flag_w%0d", i), {31'd0, overflow}, (i == 5) ? 32'd1 : 32'd0);
        end
        tx_start = 1'b0;
        chk_eq("ovf_full", {31'd0, full}, 32'd1);
        wait_idle("ovf");
        chk_eq("ovf_sticky", {31'd0, overflow}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back(8'h30 + i[7:0]);
        end
        check_frames("ovf");

        do_reset();
        chk_eq("rst2_overflow", {31'd0, overflow}, 32'd0);

        // Stream 20 bytes through the 4-entry FIFO, writing only while not full.
        wi    = 0;
        guard = 0;
        while (wi < 20 && guard < 5000) begin
            if (!full) begin
                tx_data  = 8'h10 + wi[7:0];
                tx_start = 1'b1;
                wi++;
            end else begin
                tx_start = 1'b0;
            end
            step();
            guard++;
        end
        tx_start = 1'b0;
        chk_eq("wrap_writes", wi, 32'd20);
        wait_idle("wrap");
        chk_eq("wrap_overflow", {31'd0, overflow}, 32'd0);
        for (int i = 0; i < 20; i++) begin
            exp_q.push_back(8'h10 + i[7:0]);
        end
        check_frames("wrap");

        // Full FIFO with a write landing on the STOP-end pop edge.
        write_burst(8'h40, 5);
        wait_first_frame("fp", c1);
        guard = 0;
        while (cyc < c1 + 99 && guard < 200) begin
            step();
            guard++;
        end
        chk_eq("fp_full_before", {31'd0, full}, 32'd1);
        tx_data  = 8'h55;
        tx_start = 1'b1;
        step();
        tx_start = 1'b0;
        chk_eq("fp_overflow", {31'd0, overflow}, 32'd1);
        chk_eq("fp_full_after", {31'd0, full}, 32'd0);
        chk_eq("fp_empty_after", {31'd0, empty}, 32'd0);
        wait_idle("fp");
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back(8'h40 + i[7:0]);
        end
        check_frames("fp");

        // Reset during data bit 3 of 0x60 with two bytes still queued.
        write_burst(8'h60, 3);
        wait_first_frame("mr", c1);
        guard = 0;
        while (cyc < c1 + 44 && guard < 200) begin
            step();
            guard++;
        end
        chk_eq("mr_bit3_low", {31'd0, tx}, 32'd0);
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        chk_eq("mr_tx", {31'd0, tx}, 32'd1);
        chk_eq("mr_empty", {31'd0, empty}, 32'd1);
        chk_eq("mr_busy", {31'd0, busy}, 32'd0);
        chk_eq("mr_overflow", {31'd0, overflow}, 32'd0);
        byte_q.delete();
        start_q.delete();
        lows = 0;
        for (int k = 0; k < 300; k++) begin
            step();
            if (tx !== 1'b1) begin
                lows++;
            end
        end
        chk_eq("mr_quiet_line", lows, 32'd0);
        chk_eq("mr_no_frames", byte_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
